// File: rtl/box_id_checker.sv
// box_id_checker: per-ID letter histogram reporting whether any letter occurs exactly twice or three times
module box_id_checker #(
  parameter int NUM_LETTERS = 26,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pair,
  output logic       triplet
);
  localparam int IW = (NUM_LETTERS > 1) ? $clog2(NUM_LETTERS) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_LETTERS - 1);
  localparam logic [CNT_W-1:0] C_MAX    = '1;
  localparam logic [CNT_W-1:0] C_TWO    = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_THREE  = CNT_W'(3);
  localparam logic [7:0]       NL8      = 8'(NUM_LETTERS);

  typedef enum logic [1:0] {ACCUM, SCAN, REPORT} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_bin [NUM_LETTERS];
  logic [IW-1:0]    r_idx;
  logic             r_pair_acc, r_trip_acc, r_pair, r_trip;
  logic [7:0]       w_off;
  logic [IW-1:0]    w_lidx;
  logic             w_hit, w_take, w_is2, w_is3;

  // characters below 'a' wrap to a large offset, so one compare bounds both ends
  assign w_off   = in_char - 8'h61;
  assign w_lidx  = w_off[IW-1:0];
  assign w_hit   = w_off < NL8;
  assign w_take  = in_valid && in_ready;
  assign w_is2   = r_bin[r_idx] == C_TWO;
  assign w_is3   = r_bin[r_idx] == C_THREE;
  assign pair    = r_pair;
  assign triplet = r_trip;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_state_nxt;
  end

  // next state and handshake decode from registered state only
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = (r_state == ACCUM) && !rst;
    out_valid   = r_state == REPORT;
    case (r_state)
      ACCUM:   w_state_nxt = (w_take && in_last) ? SCAN : ACCUM;
      SCAN:    w_state_nxt = (r_idx == LAST_IDX) ? REPORT : SCAN;
      REPORT:  w_state_nxt = out_ready ? ACCUM : REPORT;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // histogram update while accumulating, scan-and-clear one bin per cycle while scanning
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LETTERS; i++) r_bin[i] <= '0;
      r_idx      <= '0;
      r_pair_acc <= 1'b0;
      r_trip_acc <= 1'b0;
      r_pair     <= 1'b0;
      r_trip     <= 1'b0;
    end else if (r_state == ACCUM) begin
      if (w_take && w_hit && r_bin[w_lidx] != C_MAX) r_bin[w_lidx] <= r_bin[w_lidx] + 1'b1;
      if (w_take && in_last) begin
        r_idx      <= '0;
        r_pair_acc <= 1'b0;
        r_trip_acc <= 1'b0;
      end
    end else if (r_state == SCAN) begin
      r_bin[r_idx] <= '0;
      r_idx        <= r_idx + 1'b1;
      r_pair_acc   <= r_pair_acc | w_is2;
      r_trip_acc   <= r_trip_acc | w_is3;
      if (r_idx == LAST_IDX) begin
        r_pair <= r_pair_acc | w_is2;
        r_trip <= r_trip_acc | w_is3;
      end
    end
  end
endmodule

// File: tb/tb_box_id_checker.sv
// tb_box_id_checker: scoreboard bench comparing the histogram checker against a letter-count model
module tb_box_id_checker;
  logic       clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic [7:0] in_char = 0;
  logic       in_ready, out_valid, pair, triplet;
  int         n_chk = 0, n_err = 0, cyc = 0, gap_max = 0;
  bit         rnd_rdy = 0, force_rdy = 1, chk_ir = 0;
  logic       prev_ov = 0;

  typedef struct {logic p; logic t; int tl;} exp_t;
  typedef logic [7:0] bq_t[$];
  exp_t sb[$];

  box_id_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .pair(pair), .triplet(triplet)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(bq_t q);
    int   cnt[26];
    exp_t e;
    foreach (cnt[j]) cnt[j] = 0;
    foreach (q[i]) if (q[i] >= 8'h61 && q[i] <= 8'h7a) cnt[q[i] - 8'h61] = (cnt[q[i] - 8'h61] == 31) ? 31 : cnt[q[i] - 8'h61] + 1;
    e.p = 0; e.t = 0; e.tl = 0;
    foreach (cnt[j]) begin
      if (cnt[j] == 2) e.p = 1;
      if (cnt[j] == 3) e.t = 1;
    end
    return e;
  endfunction

  function automatic bq_t q_of(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++; n_err++;
      $display("FAIL ready_timeout: in_ready stayed %0d, required 1", in_ready);
    end
  endtask

  task automatic send(bq_t q, bit push);
    for (int i = 0; i < q.size(); i++) begin
      in_valid = 1; in_char = q[i]; in_last = (i == q.size() - 1);
      wait_ready();
      @(posedge clk); #1;
      in_valid = 0; in_last = 0;
      if (i == q.size() - 1 && push) begin
        exp_t e;
        e = model(q);
        e.tl = cyc;
        sb.push_back(e);
      end
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (sb.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
    end
  endtask

  task automatic reset_checks(string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_pair"}, pair, 0);
    chk({tag, "_triplet"}, triplet, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (chk_ir) chk("in_ready", in_ready, 32'(sb.size() == 0));
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_result: out_valid=1 with pair=%0d triplet=%0d, required no result", pair, triplet);
        end else begin
          if (!prev_ov) chk("latency", cyc - sb[0].tl, 26);
          chk("pair", pair, sb[0].p);
          chk("triplet", triplet, sb[0].t);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #1_000_000;
    n_chk++; n_err++;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    string dl[4] = '{"bababc", "abbcde", "abcccd", "ababab"};
    bq_t   q;
    int    k;
    repeat (2) @(posedge clk);
    reset_checks("reset");
    @(posedge clk); #1;
    rst = 0; chk_ir = 1;
    send(q_of("abcdef"), 1);
    drain();
    foreach (dl[i]) send(q_of(dl[i]), 1);
    send(q_of("aabbbbZ9"), 1);
    q = {}; repeat (40) q.push_back(8'h61); q.push_back(8'h62);
    send(q, 1);
    send(q_of("aab"), 1);
    q = {}; repeat (34) q.push_back(8'h61); q.push_back(8'h62);
    send(q, 1);
    q = {}; repeat (35) q.push_back(8'h61); q.push_back(8'h62);
    send(q, 1);
    drain();
    force_rdy = 0;
    @(posedge clk); #1;
    send(q_of("bababc"), 1);
    k = 0;
    while (!out_valid && k < 100) begin
      in_valid = 1'($urandom); in_char = 8'($urandom); in_last = 1'($urandom);
      @(posedge clk); #1;
      k++;
    end
    repeat (5) begin
      in_valid = 1'($urandom); in_char = 8'($urandom); in_last = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("hold_out_valid", out_valid, 1);
    in_valid = 0; in_last = 0;
    force_rdy = 1;
    drain();
    chk_ir = 0;
    send(q_of("aabccc"), 0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1;
    reset_checks("midscan_reset");
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk_ir = 1;
    send(q_of("abcdef"), 1);
    drain();
    rnd_rdy = 1; gap_max = 2;
    repeat (40) begin
      q = {};
      repeat ($urandom_range(1, 12)) q.push_back(($urandom_range(0, 9) < 9) ? 8'(8'h61 + $urandom_range(0, 4)) : 8'($urandom_range(8'h30, 8'h5a)));
      send(q, 1);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
